// File: rtl/dmem_if.sv
// Load/store bus between the execution unit (master) and a data-memory responder (slave).
// Handshake: master holds mem_sel_i and the request fields stable until it sees mem_ack_o,
// then drops mem_sel_i unless it has the next request ready; mem_err_o only means something with mem_ack_o.
interface dmem_if;
  logic        mem_sel_i;
  logic        mem_wen_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [1:0]  mem_wsize_i;
  logic [3:0]  mem_wmask_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        mem_err_o;

  modport master (
    output mem_sel_i, mem_wen_i, mem_addr_i, mem_wdata_i, mem_wsize_i, mem_wmask_i,
    input  mem_rdata_o, mem_ack_o, mem_err_o
  );

  modport slave (
    input  mem_sel_i, mem_wen_i, mem_addr_i, mem_wdata_i, mem_wsize_i, mem_wmask_i,
    output mem_rdata_o, mem_ack_o, mem_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: latches a request, waits WAIT_CYCLES, pulses ack.
// Word-organised array with per-lane write masks; misaligned/out-of-window accesses are flagged.
module dmem_responder #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_if.slave      bus,
  output logic       busy_o,
  output logic [1:0] state_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  wen_q;
  logic [3:0]            mask_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  logic [31:0] mem [DEPTH];

  logic [3:0]            eff_mask;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] req_idx;

  assign req_idx = bus.mem_addr_i[ADDR_WIDTH+1:2];

  always_comb begin
    eff_mask = bus.mem_wmask_i;
    if (bus.mem_wmask_i == 4'b0000) begin
      case (bus.mem_wsize_i)
        2'b00:   eff_mask = 4'b0001 << bus.mem_addr_i[1:0];
        2'b01:   eff_mask = bus.mem_addr_i[1] ? 4'b1100 : 4'b0011;
        default: eff_mask = 4'b1111;
      endcase
    end
  end

  always_comb begin
    req_err = (bus.mem_addr_i[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]);
    case (bus.mem_wsize_i)
      2'b01:   if (bus.mem_addr_i[0]) req_err = 1'b1;
      2'b10:   if (bus.mem_addr_i[1:0] != 2'b00) req_err = 1'b1;
      2'b11:   req_err = 1'b1;
      default: ;
    endcase
  end

  // Read data is captured on the edge that enters ACK; writes never touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      wen_q    <= 1'b0;
      mask_q   <= 4'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.mem_sel_i) begin
            idx_q   <= req_idx;
            wdata_q <= bus.mem_wdata_i;
            wen_q   <= bus.mem_wen_i;
            mask_q  <= eff_mask;
            err_q   <= req_err;
            if (WAIT_CYCLES == 0) begin
              state <= S_ACK;
              if (!bus.mem_wen_i) rdata_q <= req_err ? 32'd0 : mem[req_idx];
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_ACK;
            if (!wen_q) rdata_q <= err_q ? 32'd0 : mem[idx_q];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Commit on the edge that leaves ACK, so a reset during WAIT drops the write.
  always_ff @(posedge clk) begin
    if (state == S_ACK && wen_q && !err_q) begin
      for (int n = 0; n < 4; n++) begin
        if (mask_q[n]) mem[idx_q][8*n +: 8] <= wdata_q[8*n +: 8];
      end
    end
  end

  assign bus.mem_ack_o   = (state == S_ACK);
  assign bus.mem_err_o   = (state == S_ACK) && err_q;
  assign bus.mem_rdata_o = rdata_q;
  assign busy_o          = (state != S_IDLE);
  assign state_o         = state;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES 0 and 1) driven through a shared driver,
// checked by a per-instance scoreboard fed from a word-array reference model.
module tb_dmem_responder;
  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          WIN  = 1 << (AW + 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus0 ();
  dmem_if bus1 ();
  logic       busy0, busy1;
  logic [1:0] st0, st1;

  dmem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .busy_o(busy0), .state_o(st0));
  dmem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy_o(busy1), .state_o(st1));

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [31:0] mdl [2][1024];
  logic [31:0] last_rd [2];
  logic [31:0] obs_rdata [2];
  int          ack_cnt [2];
  bit          held [2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain word array, rules applied directly from the bus definition.
  function automatic logic [32:0] model(int k, bit wen, logic [31:0] addr, logic [31:0] wdata,
                                        logic [1:0] wsize, logic [3:0] wmask);
    bit         err;
    logic [3:0] m;
    int         idx;
    err = (addr / WIN) != (BASE / WIN);
    case (wsize)
      2'd1: if (addr % 2 != 0) err = 1;
      2'd2: if (addr % 4 != 0) err = 1;
      2'd3: err = 1;
      default: ;
    endcase
    if (wmask != 0)       m = wmask;
    else if (wsize == 0)  m = 4'(1 << (addr % 4));
    else if (wsize == 1)  m = (addr % 4 >= 2) ? 4'hC : 4'h3;
    else                  m = 4'hF;
    idx = int'((addr / 4) % 1024);
    if (wen) begin
      if (!err)
        for (int n = 0; n < 4; n++)
          if (m[n]) mdl[k][idx][8*n +: 8] = wdata[8*n +: 8];
    end else begin
      last_rd[k] = err ? 32'd0 : mdl[k][idx];
    end
    return {err, last_rd[k]};
  endfunction

  task automatic drive(int k, logic sel, logic wen, logic [31:0] addr, logic [31:0] wdata,
                       logic [1:0] wsize, logic [3:0] wmask);
    if (k == 0) begin
      bus0.mem_sel_i = sel; bus0.mem_wen_i = wen; bus0.mem_addr_i = addr;
      bus0.mem_wdata_i = wdata; bus0.mem_wsize_i = wsize; bus0.mem_wmask_i = wmask;
    end else begin
      bus1.mem_sel_i = sel; bus1.mem_wen_i = wen; bus1.mem_addr_i = addr;
      bus1.mem_wdata_i = wdata; bus1.mem_wsize_i = wsize; bus1.mem_wmask_i = wmask;
    end
  endtask

  function automatic logic ack_of(int k);
    return (k == 0) ? bus0.mem_ack_o : bus1.mem_ack_o;
  endfunction

  function automatic logic busy_of(int k);
    return (k == 0) ? busy0 : busy1;
  endfunction

  // Issue one request; with hold=1 sel stays high so the next call forms a back-to-back pair.
  task automatic do_req(int k, bit wen, logic [31:0] addr, logic [31:0] wdata,
                        logic [1:0] wsize, logic [3:0] wmask, bit hold);
    int  lat;
    int  exp_lat;
    bit  got;
    exp_lat = ((k == 0) ? 1 : 2) + (held[k] ? 1 : 0);
    if (k == 0) exp_q0.push_back(model(k, wen, addr, wdata, wsize, wmask));
    else        exp_q1.push_back(model(k, wen, addr, wdata, wsize, wmask));
    drive(k, 1'b1, wen, addr, wdata, wsize, wmask);
    got = 0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ack_of(k) === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: inst %0d got no ack expected ack within 40 cycles", k);
      hold = 0;
    end else begin
      chk("ack_latency", 32'(lat), 32'(exp_lat));
      chk("busy_in_ack", {31'd0, busy_of(k)}, 32'd1);
    end
    held[k] = hold;
    if (!hold) begin
      drive(k, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 4'd0);
      @(negedge clk);
    end
  endtask

  task automatic mon(int k, logic ack, logic err, logic [31:0] rd);
    logic [32:0] e;
    checks++;
    if (ack !== 1'b1 && err !== 1'b0) begin
      errors++;
      $display("FAIL err_qualifier: inst %0d got err=%b expected 0 without ack", k, err);
    end
    if (ack === 1'b1) begin
      ack_cnt[k]++;
      obs_rdata[k] = rd;
      checks++;
      if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        errors++;
        $display("FAIL unexpected_ack: inst %0d got ack expected none", k);
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if ({err, rd} !== e) begin
          errors++;
          $display("FAIL response: inst %0d got err=%b rdata=%h expected err=%b rdata=%h",
                   k, err, rd, e[32], e[31:0]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.mem_ack_o, bus0.mem_err_o, bus0.mem_rdata_o);
    mon(1, bus1.mem_ack_o, bus1.mem_err_o, bus1.mem_rdata_o);
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ack0"},   {31'd0, bus0.mem_ack_o}, 32'd0);
    chk({tag, "_err0"},   {31'd0, bus0.mem_err_o}, 32'd0);
    chk({tag, "_rdata0"}, bus0.mem_rdata_o,        32'd0);
    chk({tag, "_busy0"},  {31'd0, busy0},          32'd0);
    chk({tag, "_ack1"},   {31'd0, bus1.mem_ack_o}, 32'd0);
    chk({tag, "_err1"},   {31'd0, bus1.mem_err_o}, 32'd0);
    chk({tag, "_rdata1"}, bus1.mem_rdata_o,        32'd0);
    chk({tag, "_busy1"},  {31'd0, busy1},          32'd0);
  endtask

  initial begin
    int n0;
    logic [31:0] a;
    logic [3:0]  wm;
    last_rd[0] = 0; last_rd[1] = 0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    held[0] = 0; held[1] = 0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 4'd0);

    // Clock/reset
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed, WAIT_CYCLES=1 instance
    do_req(1, 1, 32'h10, 32'hDEADBEEF, 2'd2, 4'hF, 0);
    do_req(1, 0, 32'h10, 32'h0, 2'd2, 4'h0, 0);
    chk("lw_after_sw", obs_rdata[1], 32'hDEADBEEF);
    do_req(1, 1, 32'h10, 32'h11223344, 2'd2, 4'hF, 0);
    do_req(1, 1, 32'h13, 32'hAA000000, 2'd0, 4'h8, 0);
    do_req(1, 0, 32'h10, 32'h0, 2'd2, 4'h0, 0);
    chk("sb_lane3", obs_rdata[1], 32'hAA223344);
    do_req(1, 1, 32'h10, 32'h0, 2'd2, 4'hF, 0);
    do_req(1, 1, 32'h12, 32'h55660000, 2'd1, 4'h0, 0);
    do_req(1, 0, 32'h10, 32'h0, 2'd2, 4'h0, 0);
    chk("sh_derived_mask", obs_rdata[1], 32'h55660000);
    do_req(1, 1, 32'h0, 32'h0BADF00D, 2'd2, 4'hF, 0);
    do_req(1, 0, 32'h11, 32'h0, 2'd2, 4'h0, 0);
    chk("misaligned_rdata", obs_rdata[1], 32'h0);
    do_req(1, 1, BASE + 32'h1000, 32'hFFFFFFFF, 2'd2, 4'hF, 0);
    do_req(1, 0, 32'h0, 32'h0, 2'd2, 4'h0, 0);
    chk("oor_no_write", obs_rdata[1], 32'h0BADF00D);

    // Back-to-back, WAIT_CYCLES=0 instance, sel held across ACK
    n0 = ack_cnt[0];
    do_req(0, 1, 32'h40, 32'h11111111, 2'd2, 4'hF, 1);
    do_req(0, 0, 32'h40, 32'h0, 2'd2, 4'h0, 1);
    do_req(0, 1, 32'h40, 32'h000000EE, 2'd0, 4'h0, 1);
    do_req(0, 1, 32'h41, 32'h0000DD00, 2'd0, 4'h0, 1);
    do_req(0, 0, 32'h40, 32'h0, 2'd2, 4'h0, 0);
    chk("b2b_rdata", obs_rdata[0], 32'h1111DDEE);
    chk("b2b_ack_count", 32'(ack_cnt[0] - n0), 32'd5);

    // Reset during WAIT of a store: no ack, no commit
    do_req(1, 1, 32'h20, 32'h12345678, 2'd2, 4'hF, 0);
    drive(1, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 2'd2, 4'hF);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 4'd0);
    chk("busy_in_wait", {31'd0, busy1}, 32'd1);
    rst_n = 1'b0;
    last_rd[0] = 0; last_rd[1] = 0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_req(1, 0, 32'h20, 32'h0, 2'd2, 4'h0, 0);
    chk("abort_no_commit", obs_rdata[1], 32'h12345678);

    // Randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) do_req(k, 1, 32'(w * 4), $urandom, 2'd2, 4'hF, 0);
      for (int t = 0; t < 150; t++) begin
        if ($urandom_range(0, 9) == 0) a = BASE + 32'h1000 + 32'($urandom_range(0, 63));
        else                           a = BASE + 32'($urandom_range(0, 63));
        wm = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        do_req(k, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)), wm,
               (t == 149) ? 1'b0 : 1'($urandom_range(0, 1)));
      end
    end

    repeat (5) @(negedge clk);
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish expected completion before 2ms");
    $fatal(1);
  end
endmodule
